led_seq_ctrl: RTL

//  Sequencer for the LED pattern memory: owns the pattern PC, paces it with a

---
 rtl/led_seq_pkg.sv | 8 +
 rtl/led_seq_prescaler.sv | 22 ++
 rtl/led_seq_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared state encoding and default geometry for the LED pattern sequencer
package led_seq_pkg;
  typedef enum logic {IDLE, RUN} state_e;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 5;
  localparam int DEPTH_DEF  = 21;
  localparam int DIV_W_DEF  = 24;
endpackage

// File: rtl/led_seq_prescaler.sv
// led_seq_prescaler: loadable down-counter that flags tick while the count sits at zero
module led_seq_prescaler #(
  parameter int W = 24
) (
  input  logic         CLK,
  input  logic         resetn,
  input  logic         en,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] load_val,
  output logic         tick
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = clear ? '0 : load ? load_val : (en && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
    tick  = (cnt_q == '0);
  end
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: paces the pattern PC with a prescaler and drives a 1-cycle-latency pattern memory read port
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic              CLK,
  input  logic              resetn,
  input  logic              start,
  input  logic              stop,
  input  logic              step,
  input  logic              oneshot,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [DIV_W-1:0]  div,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] leds,
  output logic              busy,
  output logic              done
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, sa_q, sa_d, ea_q, ea_d, mem_addr_q, mem_addr_d, nxt;
  logic [DIV_W-1:0]  div_q, div_d, pre_val;
  logic [DATA_W-1:0] leds_q, leds_d;
  logic              os_q, os_d, mem_rd_q, mem_rd_d, rd_dly_q, busy_q, busy_d, done_q, done_d;
  logic              pre_load, pre_clear, tick;

  function automatic logic [ADDR_W-1:0] coerce(input logic [ADDR_W-1:0] a);
    return (int'(a) >= DEPTH) ? '0 : a;
  endfunction

  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] a);
    return (int'(a) == DEPTH - 1) ? '0 : a + ADDR_W'(1);
  endfunction

  led_seq_prescaler #(.W(DIV_W)) u_pre (
    .CLK      (CLK),
    .resetn   (resetn),
    .en       (state_q == RUN),
    .load     (pre_load),
    .clear    (pre_clear),
    .load_val (pre_val),
    .tick     (tick)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    sa_d       = sa_q;
    ea_d       = ea_q;
    div_d      = div_q;
    os_d       = os_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = 1'b0;
    done_d     = 1'b0;
    pre_load   = 1'b0;
    pre_clear  = 1'b0;
    pre_val    = div_q;
    nxt        = (pc_q == ea_q) ? sa_q : next_pc(pc_q);
    leds_d     = rd_dly_q ? mem_rdata : leds_q;
    if (stop) begin
      state_d   = IDLE;
      pre_clear = 1'b1;
    end else if (start) begin
      state_d    = RUN;
      sa_d       = coerce(start_addr);
      ea_d       = coerce(end_addr);
      div_d      = div;
      os_d       = oneshot;
      pc_d       = sa_d;
      mem_addr_d = sa_d;
      mem_rd_d   = 1'b1;
      pre_load   = 1'b1;
      pre_val    = div;
    end else if (state_q == RUN) begin
      if (tick && pc_q == ea_q && os_q) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else if (tick) begin
        pc_d       = nxt;
        mem_addr_d = nxt;
        mem_rd_d   = 1'b1;
        pre_load   = 1'b1;
      end
    end else if (step) begin
      pc_d       = next_pc(pc_q);
      mem_addr_d = pc_d;
      mem_rd_d   = 1'b1;
    end
    busy_d = (state_d == RUN);
  end

  // rd_dly_q marks the cycle in which the memory presents data for the previous strobe
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      sa_q       <= '0;
      ea_q       <= '0;
      div_q      <= '0;
      os_q       <= 1'b0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      rd_dly_q   <= 1'b0;
      leds_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      sa_q       <= sa_d;
      ea_q       <= ea_d;
      div_q      <= div_d;
      os_q       <= os_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      rd_dly_q   <= mem_rd_q;
      leds_q     <= leds_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_rd   = mem_rd_q;
  assign leds     = leds_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule
